// File: rtl/grover_pkg.sv
// Shared definitions for the Grover measurement block: default sizes,
// the FSM state encoding and the 16-bit Galois LFSR step.
package grover_pkg;

  localparam int NUM_BIT        = 3;
  localparam int FIXEDPOINT_BIT = 8;
  localparam int NUM_SAMPLE     = 2 ** NUM_BIT;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
  localparam logic [15:0] LFSR_POLY         = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

  typedef enum logic [2:0] {
    IDLE,
    SQUARE,
    DRAW,
    SCAN,
    OUT
  } state_t;

  // One LFSR step: shift right, fold the feedback mask in when a one falls out.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    lfsr_step = {1'b0, v[15:1]} ^ (v[0] ? LFSR_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; advances on every clock, reloads the seed
// on reset. The seed must be nonzero or the sequence locks at zero.
module lfsr16 import grover_pkg::*; #(
  parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] lfsr
);

  // Advance unconditionally so the draw value depends on when DRAW happens.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr <= SEED;
    else      lfsr <= lfsr_step(lfsr);
  end

endmodule

// File: rtl/grover_measure.sv
// Grover measurement: samples a basis-state index with probability
// proportional to the squared amplitude. Amplitudes are captured, squared
// one per cycle into a cumulative table, a random threshold below the total
// is drawn from the LFSR, and the table is scanned for the first entry above
// it. Optional macro GROVER_MEAS_ARGMAX_EN adds an argmax_idx output.
module grover_measure #(
  parameter int          NUM_BIT        = grover_pkg::NUM_BIT,
  parameter int          FIXEDPOINT_BIT = grover_pkg::FIXEDPOINT_BIT,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  input  logic                                       amp_valid,
  input  logic [(2**NUM_BIT)*FIXEDPOINT_BIT-1:0]     amp_in,
  output logic                                       meas_valid,
  input  logic                                       meas_ready,
  output logic [NUM_BIT-1:0]                         meas_idx,
  output logic [2*FIXEDPOINT_BIT-2:0]                meas_prob,
  output logic                                       zero_err,
  output logic                                       busy
`ifdef GROVER_MEAS_ARGMAX_EN
  ,
  output logic [NUM_BIT-1:0]                         argmax_idx
`endif
);

  localparam int NUM_SAMPLE = 2 ** NUM_BIT;

  import grover_pkg::*;

  // A square of an FP-bit signed value needs 2*FP-1 bits; summing NUM_SAMPLE
  // of them adds NUM_BIT bits, so the running sum can never overflow.
  localparam int SQW = 2 * FIXEDPOINT_BIT - 1;
  localparam int CW  = SQW + NUM_BIT;
  localparam logic [NUM_BIT-1:0] LAST_IDX = NUM_BIT'(NUM_SAMPLE - 1);

  state_t state_reg, state_next;

  logic signed [FIXEDPOINT_BIT-1:0] amp_in_arr [NUM_SAMPLE];
  logic signed [FIXEDPOINT_BIT-1:0] amp_reg    [NUM_SAMPLE];
  logic        [CW-1:0]             cum_reg    [NUM_SAMPLE];
  logic        [CW-1:0]             acc_reg;
  logic        [CW-1:0]             r_reg;
  logic        [NUM_BIT-1:0]        k_reg;
  logic        [15:0]               lfsr_val;

  logic [FIXEDPOINT_BIT-1:0] mag;
  logic [SQW-1:0]            mag_ext;
  logic [SQW-1:0]            sq_cur;
  logic [CW-1:0]             total;
  logic [CW-1:0]             r_next;
  logic                      hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SAMPLE; gi++) begin : g_unpack
      assign amp_in_arr[gi] = amp_in[gi*FIXEDPOINT_BIT +: FIXEDPOINT_BIT];
    end
  endgenerate

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .lfsr (lfsr_val)
  );

  // Shared squarer on amp_reg[k_reg], plus draw threshold and scan compare.
  // The magnitude of -2^(FP-1) still fits in FP unsigned bits.
  always_comb begin
    mag     = amp_reg[k_reg][FIXEDPOINT_BIT-1] ? FIXEDPOINT_BIT'(-amp_reg[k_reg])
                                               : FIXEDPOINT_BIT'(amp_reg[k_reg]);
    mag_ext = SQW'(mag);
    sq_cur  = mag_ext * mag_ext;
    total   = cum_reg[NUM_SAMPLE-1];
    r_next  = CW'(({{CW{1'b0}}, lfsr_val} * {16'h0000, total}) >> 16);
    hit     = (r_reg < cum_reg[k_reg]);
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state_reg;
    meas_valid = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (start && amp_valid) state_next = SQUARE;
      end
      SQUARE: if (k_reg == LAST_IDX) state_next = DRAW;
      DRAW:   state_next = (total == '0) ? OUT : SCAN;
      SCAN:   if (hit) state_next = OUT;
      OUT: begin
        meas_valid = 1'b1;
        if (meas_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture, cumulative squares, threshold draw, scan and result hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_SAMPLE; i++) begin
        amp_reg[i] <= '0;
        cum_reg[i] <= '0;
      end
      acc_reg   <= '0;
      r_reg     <= '0;
      k_reg     <= '0;
      meas_idx  <= '0;
      meas_prob <= '0;
      zero_err  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start && amp_valid) begin
            for (int i = 0; i < NUM_SAMPLE; i++) amp_reg[i] <= amp_in_arr[i];
            acc_reg <= '0;
            k_reg   <= '0;
          end
        end
        SQUARE: begin
          cum_reg[k_reg] <= acc_reg + CW'(sq_cur);
          acc_reg        <= acc_reg + CW'(sq_cur);
          k_reg          <= k_reg + NUM_BIT'(1);
        end
        DRAW: begin
          r_reg <= r_next;
          k_reg <= '0;
          if (total == '0) begin
            meas_idx  <= '0;
            meas_prob <= '0;
            zero_err  <= 1'b1;
          end
        end
        SCAN: begin
          // r < total guarantees a hit no later than the last index.
          if (hit) begin
            meas_idx  <= k_reg;
            meas_prob <= sq_cur;
            zero_err  <= 1'b0;
          end else begin
            k_reg <= k_reg + NUM_BIT'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef GROVER_MEAS_ARGMAX_EN
  logic [SQW-1:0] max_reg;

  // Track the largest square while squaring; strict compare keeps the lowest index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      max_reg    <= '0;
      argmax_idx <= '0;
    end else if (state_reg == IDLE && start && amp_valid) begin
      max_reg    <= '0;
      argmax_idx <= '0;
    end else if (state_reg == SQUARE && sq_cur > max_reg) begin
      max_reg    <= sq_cur;
      argmax_idx <= k_reg;
    end
  end
`endif

endmodule

// File: tb/tb_grover_measure.sv
// Self-checking bench for grover_measure (default parameters: 8 samples of
// 8-bit amplitudes). A transaction-level model predicts each result from the
// amplitudes and the LFSR value at the draw cycle; a negedge process compares
// every output every cycle, and directed scenarios add literal expectations.
module tb_grover_measure;

  localparam int NB = 3;
  localparam int FP = 8;
  localparam int NS = 8;

  logic              clk;
  logic              rst;
  logic              start;
  logic              amp_valid;
  logic [NS*FP-1:0]  amp_in;
  logic              meas_valid;
  logic              meas_ready;
  logic [NB-1:0]     meas_idx;
  logic [2*FP-2:0]   meas_prob;
  logic              zero_err;
  logic              busy;
`ifdef GROVER_MEAS_ARGMAX_EN
  logic [NB-1:0]     argmax_idx;
`endif

  grover_measure dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .amp_valid  (amp_valid),
    .amp_in     (amp_in),
    .meas_valid (meas_valid),
    .meas_ready (meas_ready),
    .meas_idx   (meas_idx),
    .meas_prob  (meas_prob),
    .zero_err   (zero_err),
    .busy       (busy)
`ifdef GROVER_MEAS_ARGMAX_EN
    ,
    .argmax_idx (argmax_idx)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_txn    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Galois form of x^16+x^14+x^13+x^11+1: feedback taps at bits 15,13,12,10.
  function automatic logic [15:0] step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  // Expected outcome of one measurement from the amplitudes and the draw value.
  task automatic predict(input logic [NS*FP-1:0] amps, input logic [15:0] l_draw,
                         output int idx, output int prob, output bit zero,
                         output int lat, output int amax);
    longint sq [NS];
    longint total, r, run, best;
    total = 0;
    best  = -1;
    amax  = 0;
    for (int k = 0; k < NS; k++) begin
      int a;
      a = $signed(amps[k*FP +: FP]);
      sq[k] = longint'(a) * longint'(a);
      total += sq[k];
      if (sq[k] > best) begin
        best = sq[k];
        amax = k;
      end
    end
    if (total == 0) begin
      idx  = 0;
      prob = 0;
      zero = 1'b1;
      lat  = 1 + NS + 1;
    end else begin
      r   = (longint'(l_draw) * total) >> 16;
      run = 0;
      idx = -1;
      for (int k = 0; k < NS; k++) begin
        run += sq[k];
        if (idx < 0 && r < run) idx = k;
      end
      prob = int'(sq[idx]);
      zero = 1'b0;
      lat  = 1 + NS + 1 + idx + 1;
    end
  endtask

  // Model state: what the outputs must be after each clock edge.
  logic [15:0] lfsr_m;
  bit m_busy, m_valid, e_zero, p_zero;
  int m_cnt, e_idx, e_prob, e_amax;
  int p_idx, p_prob, p_lat, p_amax;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_m  = 16'hACE1;
      m_busy  = 1'b0;
      m_valid = 1'b0;
      m_cnt   = 0;
      e_idx   = 0;
      e_prob  = 0;
      e_zero  = 1'b0;
      e_amax  = 0;
    end else begin
      if (m_valid) begin
        if (meas_ready) begin
          m_valid = 1'b0;
          m_busy  = 1'b0;
        end
      end else if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_valid = 1'b1;
          e_idx   = p_idx;
          e_prob  = p_prob;
          e_zero  = p_zero;
          e_amax  = p_amax;
        end
      end else if (start && amp_valid) begin
        logic [15:0] l;
        l = lfsr_m;
        // The draw happens 1+NS edges after the capture edge.
        repeat (1 + NS) l = step(l);
        predict(amp_in, l, p_idx, p_prob, p_zero, p_lat, p_amax);
        m_busy = 1'b1;
        m_cnt  = p_lat - 1;
      end
      lfsr_m = step(lfsr_m);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("busy", busy, m_busy);
    chk("meas_valid", meas_valid, m_valid);
    chk("meas_idx", meas_idx, e_idx);
    chk("meas_prob", meas_prob, e_prob);
    chk("zero_err", zero_err, e_zero);
`ifdef GROVER_MEAS_ARGMAX_EN
    if (m_valid) chk("argmax_idx", argmax_idx, e_amax);
`endif
    if (meas_valid && meas_ready) begin
      n_txn++;
      $display("txn %0d: idx=%0d prob=%0d zero_err=%0d", n_txn, meas_idx, meas_prob, zero_err);
    end
  end

  // Issue one start and wait (bounded) for the result, then complete the handshake.
  task automatic run_meas(input logic [NS*FP-1:0] amps, output int lat, output int idx,
                          output int prob, output int zero, output int amax);
    amp_in    = amps;
    amp_valid = 1'b1;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 1;
    while (!meas_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!meas_valid) chk("meas_valid_timeout", 0, 1);
    idx  = meas_idx;
    prob = meas_prob;
    zero = zero_err;
`ifdef GROVER_MEAS_ARGMAX_EN
    amax = argmax_idx;
`else
    amax = 0;
`endif
    @(posedge clk); #1;
  endtask

  logic [NS*FP-1:0] amps;
  int lat, idx, prob, zero, amax;
  int cnt [NS];

  initial begin
    rst        = 1'b0;
    start      = 1'b0;
    amp_valid  = 1'b0;
    amp_in     = '0;
    meas_ready = 1'b1;

    chk("lfsr_model_step", step(16'hACE1), 16'hE270);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_meas_valid", meas_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_meas_idx", meas_idx, 0);
    chk("reset_meas_prob", meas_prob, 0);
    chk("reset_zero_err", zero_err, 0);
`ifdef GROVER_MEAS_ARGMAX_EN
    chk("reset_argmax_idx", argmax_idx, 0);
`endif
    rst = 1'b1;
    @(posedge clk); #1;

    // start without amp_valid is ignored
    start = 1'b1;
    amp_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_no_amp_valid_busy", busy, 0);

    // all-zero amplitudes
    amps = '0;
    run_meas(amps, lat, idx, prob, zero, amax);
    chk("zero_latency", lat, 10);
    chk("zero_idx", idx, 0);
    chk("zero_prob", prob, 0);
    chk("zero_err_flag", zero, 1);

    // single nonzero amplitude at index 5
    amps = '0;
    amps[5*FP +: FP] = 8'd64;
    for (int n = 0; n < 100; n++) begin
      run_meas(amps, lat, idx, prob, zero, amax);
      if (n == 0) begin
        chk("amp5_latency", lat, 16);
        chk("amp5_zero_err", zero, 0);
      end
      chk("amp5_idx", idx, 5);
      chk("amp5_prob", prob, 4096);
`ifdef GROVER_MEAS_ARGMAX_EN
      chk("amp5_argmax", amax, 5);
`endif
    end

    // negative amplitude: sign ignored
    amps = '0;
    amps[2*FP +: FP] = 8'h9C;
    run_meas(amps, lat, idx, prob, zero, amax);
    chk("neg_idx", idx, 2);
    chk("neg_prob", prob, 10000);
    chk("neg_latency", lat, 13);

    // uniform amplitudes: roughly uniform index distribution
    for (int k = 0; k < NS; k++) cnt[k] = 0;
    amps = {NS{8'd22}};
    for (int n = 0; n < 800; n++) begin
      run_meas(amps, lat, idx, prob, zero, amax);
      cnt[idx]++;
      if (n == 0) chk("uniform_prob", prob, 484);
    end
    for (int k = 0; k < NS; k++) begin
      n_checks++;
      if (cnt[k] >= 60 && cnt[k] <= 140) n_pass++;
      else $display("FAIL uniform_count_idx%0d: got %0d, required 60..140", k, cnt[k]);
    end

    // back-pressure: outputs hold while meas_ready is low; starts ignored
    amps = '0;
    amps[5*FP +: FP] = 8'd64;
    meas_ready = 1'b0;
    amp_in     = amps;
    amp_valid  = 1'b1;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!meas_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("hold_first_valid", meas_valid, 1);
    for (int c = 0; c < 5; c++) begin
      start  = 1'b1;
      amp_in = {NS{8'd7}};
      @(posedge clk); #1;
      chk("hold_valid", meas_valid, 1);
      chk("hold_idx", meas_idx, 5);
      chk("hold_prob", meas_prob, 4096);
      chk("hold_zero_err", zero_err, 0);
    end
    start      = 1'b0;
    meas_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold_release_busy", busy, 0);
    chk("hold_release_valid", meas_valid, 0);

    // reset in the middle of SCAN aborts without a result
    amps = '0;
    amps[7*FP +: FP] = 8'd64;
    amp_in    = amps;
    amp_valid = 1'b1;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    chk("pre_abort_busy", busy, 1);
    rst = 1'b0;
    #1;
    chk("abort_meas_valid", meas_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_meas_idx", meas_idx, 0);
    chk("abort_meas_prob", meas_prob, 0);
`ifdef GROVER_MEAS_ARGMAX_EN
    chk("abort_argmax_idx", argmax_idx, 0);
`endif
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    run_meas(amps, lat, idx, prob, zero, amax);
    chk("after_abort_idx", idx, 7);
    chk("after_abort_prob", prob, 4096);
    chk("after_abort_latency", lat, 18);

    repeat (2) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
